// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: IDU instruction encoding plus the stack sequencer's op, state and SP default.
package gb_cpu_common_pkg;

    typedef enum logic [1:0] {
        IDU_NOP = 2'd0,
        IDU_INC = 2'd1,
        IDU_DEC = 2'd2
    } idu_op_t;

    typedef struct packed {
        idu_op_t     op;
        logic [15:0] addr;
    } idu_instruction_t;

    typedef enum logic {
        STACK_PUSH = 1'b0,
        STACK_POP  = 1'b1
    } stack_op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH_DEC = 3'd1,
        PUSH_HI  = 3'd2,
        PUSH_LO  = 3'd3,
        POP_LO   = 3'd4,
        POP_HI   = 3'd5
    } stack_state_t;

    localparam logic [15:0] SP_DEFAULT = 16'hFFFE;

    // States that place SP on the bus (everything except IDLE and the pre-decrement cycle).
    function automatic logic is_access_state(input stack_state_t s);
        return (s == PUSH_HI) || (s == PUSH_LO) || (s == POP_LO) || (s == POP_HI);
    endfunction

endpackage

// File: rtl/gb_cpu_stack_seq_if.sv
// Control-unit and memory-bus signals of the stack sequencer; slave = sequencer, master = its environment.
interface gb_cpu_stack_seq_if;
    import gb_cpu_common_pkg::*;

    logic         start;
    stack_op_t    op;
    logic [15:0]  push_data;
    logic         sp_load;
    logic [15:0]  sp_wdata;
    logic [7:0]   mem_rdata;
    logic [15:0]  sp;
    logic         busy;
    logic         done;
    logic [15:0]  pop_data;
    logic [15:0]  mem_addr;
    logic         mem_wr;
    logic         mem_rd;
    logic [7:0]   mem_wdata;
    logic         sp_wrap_err;
    stack_state_t state;

    modport slave (
        input  start, op, push_data, sp_load, sp_wdata, mem_rdata,
        output sp, busy, done, pop_data, mem_addr, mem_wr, mem_rd, mem_wdata, sp_wrap_err, state
    );

    modport master (
        output start, op, push_data, sp_load, sp_wdata, mem_rdata,
        input  sp, busy, done, pop_data, mem_addr, mem_wr, mem_rd, mem_wdata, sp_wrap_err, state
    );

endinterface

// File: rtl/gb_cpu_idu.sv
// Increment/decrement unit: 16-bit modulo INC/DEC/pass-through of the supplied address.
module gb_cpu_idu
    import gb_cpu_common_pkg::*;
(
    input  idu_instruction_t instr,
    output logic [15:0]      out
);

    always_comb begin
        out = instr.addr;
        case (instr.op)
            IDU_INC: out = instr.addr + 16'd1;
            IDU_DEC: out = instr.addr - 16'd1;
            default: out = instr.addr;
        endcase
    end

endmodule

// File: rtl/gb_cpu_stack_seq.sv
// PUSH/POP stack-pointer sequencer driving the CPU bus one M-cycle per clk.
// Optional SP wrap detection is enabled with `define GB_CPU_STACK_WRAP_CHECK_EN.
module gb_cpu_stack_seq
    import gb_cpu_common_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    gb_cpu_stack_seq_if.slave bus
);

    // Handshake: start is a level request accepted only on a clk edge where state is IDLE
    // and sp_load is low; done pulses for exactly one cycle and that cycle is already IDLE,
    // so a start held through it launches the next op without a gap.

    stack_state_t     state_q, state_d;
    logic [15:0]      sp_q, sp_d;
    logic [15:0]      data_q;
    logic [7:0]       lo_q;
    logic [15:0]      pop_q;
    logic             done_q;
    logic             wrap_q;
    idu_op_t          idu_op;
    idu_instruction_t idu_instr;
    logic [15:0]      idu_out;
    logic             accept;
    logic             load;

    assign load   = (state_q == IDLE) && bus.sp_load;
    assign accept = (state_q == IDLE) && bus.start && !bus.sp_load;

    always_comb begin
        state_d = state_q;
        idu_op  = IDU_NOP;
        case (state_q)
            IDLE: begin
                if (accept) state_d = (bus.op == STACK_PUSH) ? PUSH_DEC : POP_LO;
            end
            PUSH_DEC: begin
                idu_op  = IDU_DEC;
                state_d = PUSH_HI;
            end
            PUSH_HI: begin
                idu_op  = IDU_DEC;
                state_d = PUSH_LO;
            end
            PUSH_LO: state_d = IDLE;
            POP_LO: begin
                idu_op  = IDU_INC;
                state_d = POP_HI;
            end
            POP_HI: begin
                idu_op  = IDU_INC;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign idu_instr = '{op: idu_op, addr: sp_q};

    gb_cpu_idu u_idu (
        .instr (idu_instr),
        .out   (idu_out)
    );

    // A NOP through the IDU returns sp unchanged, so SP simply follows the IDU output.
    assign sp_d = load ? bus.sp_wdata : idu_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sp_q    <= SP_RESET;
            data_q  <= 16'h0000;
            lo_q    <= 8'h00;
            pop_q   <= 16'h0000;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            done_q  <= (state_q == PUSH_LO) || (state_q == POP_HI);
            if (accept)             data_q <= bus.push_data;
            if (state_q == POP_LO)  lo_q   <= bus.mem_rdata;
            if (state_q == POP_HI)  pop_q  <= {bus.mem_rdata, lo_q};
        end
    end

`ifdef GB_CPU_STACK_WRAP_CHECK_EN
    logic wrap_d;

    always_comb begin
        wrap_d = wrap_q;
        if (load) begin
            wrap_d = 1'b0;
        end else if ((idu_op == IDU_DEC && sp_q == 16'h0000) ||
                     (idu_op == IDU_INC && sp_q == 16'hFFFF)) begin
            wrap_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) wrap_q <= 1'b0;
        else       wrap_q <= wrap_d;
    end
`else
    assign wrap_q = 1'b0;
`endif

    always_comb begin
        bus.mem_wdata = 8'h00;
        if (state_q == PUSH_HI) bus.mem_wdata = data_q[15:8];
        if (state_q == PUSH_LO) bus.mem_wdata = data_q[7:0];
    end

    assign bus.mem_addr    = is_access_state(state_q) ? sp_q : 16'h0000;
    assign bus.mem_wr      = (state_q == PUSH_HI) || (state_q == PUSH_LO);
    assign bus.mem_rd      = (state_q == POP_LO) || (state_q == POP_HI);
    assign bus.sp          = sp_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.pop_data    = pop_q;
    assign bus.sp_wrap_err = wrap_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_gb_cpu_stack_seq.sv
// Self-checking bench for gb_cpu_stack_seq against a byte-addressed stack model.
module tb_gb_cpu_stack_seq;
    import gb_cpu_common_pkg::*;

`ifdef GB_CPU_STACK_WRAP_CHECK_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gb_cpu_stack_seq_if bus ();

    gb_cpu_stack_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem   [0:65535];
    logic [7:0]  m_mem [0:65535];
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];
    logic [15:0] exp_rd_q[$];
    logic [15:0] obs_rd_q[$];
    logic [15:0] m_sp;
    logic [15:0] m_pop;
    logic        m_wrap;

    assign bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr] : 8'h00;

    // Bus responder and monitor
    always @(posedge clk) begin
        total++;
        if (bus.mem_wr && bus.mem_rd) begin
            bad++;
            $display("FAIL strobe_excl: wr=%0b rd=%0b both high", bus.mem_wr, bus.mem_rd);
        end
        if (bus.mem_wr) begin
            obs_q.push_back({bus.mem_addr, bus.mem_wdata});
            mem[bus.mem_addr] = bus.mem_wdata;
        end
        if (bus.mem_rd) obs_rd_q.push_back(bus.mem_addr);
    end

    task automatic model_push(input logic [15:0] d);
        logic [15:0] a_hi, a_lo;
        a_hi = m_sp - 16'd1;
        a_lo = m_sp - 16'd2;
        exp_q.push_back({a_hi, d[15:8]});
        exp_q.push_back({a_lo, d[7:0]});
        m_mem[a_hi] = d[15:8];
        m_mem[a_lo] = d[7:0];
        if (m_sp < 16'd2) m_wrap = WRAP_EN;
        m_sp = a_lo;
    endtask

    task automatic model_pop();
        logic [15:0] a_lo, a_hi;
        a_lo = m_sp;
        a_hi = m_sp + 16'd1;
        exp_rd_q.push_back(a_lo);
        exp_rd_q.push_back(a_hi);
        m_pop = {m_mem[a_hi], m_mem[a_lo]};
        if (m_sp > 16'hFFFD) m_wrap = WRAP_EN;
        m_sp = m_sp + 16'd2;
    endtask

    task automatic clear_queues();
        exp_q.delete(); obs_q.delete(); exp_rd_q.delete(); obs_rd_q.delete();
    endtask

    task automatic run_op(input stack_op_t o, input logic [15:0] d, output int lat);
        bus.op = o; bus.push_data = d; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (!bus.done) begin
            bad++;
            $display("FAIL op_timeout: done=%0b after %0d cycles, need 1", bus.done, lat);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.sp_load = 1'b1; bus.sp_wdata = v;
        @(posedge clk); #1;
        bus.sp_load = 1'b0;
        m_sp = v; m_wrap = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        m_sp = 16'hFFFE; m_pop = 16'h0000; m_wrap = 1'b0;
        total += 7;
        if (bus.sp !== 16'hFFFE) begin bad++; $display("FAIL rst_sp: got %h exp fffe", bus.sp); end
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b exp 0", bus.done); end
        if (bus.mem_wr !== 1'b0 || bus.mem_rd !== 1'b0) begin
            bad++; $display("FAIL rst_strobes: got wr=%b rd=%b exp 0 0", bus.mem_wr, bus.mem_rd);
        end
        if (bus.pop_data !== 16'h0000) begin bad++; $display("FAIL rst_pop: got %h exp 0000", bus.pop_data); end
        if (bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 8'h00) begin
            bad++; $display("FAIL rst_bus: got addr=%h wdata=%h exp 0000 00", bus.mem_addr, bus.mem_wdata);
        end
        if (bus.sp_wrap_err !== 1'b0) begin bad++; $display("FAIL rst_wrap: got %b exp 0", bus.sp_wrap_err); end
    endtask

    task automatic test_push_pop();
        int lat;
        bit ok;
        clear_queues();
        model_push(16'h1234);
        run_op(STACK_PUSH, 16'h1234, lat);
        total += 3;
        if (lat != 4) begin bad++; $display("FAIL push_lat: got %0d exp 4", lat); end
        if (bus.sp !== 16'hFFFC) begin bad++; $display("FAIL push_sp: got %h exp fffc", bus.sp); end
        ok = (obs_q.size() == 2) && (obs_q[0] === 24'hFFFD12) && (obs_q[1] === 24'hFFFC34);
        if (!ok) begin bad++; $display("FAIL push_writes: got n=%0d exp fffd<=12 fffc<=34", obs_q.size()); end
        clear_queues();
        model_pop();
        run_op(STACK_POP, 16'h0000, lat);
        total += 4;
        if (lat != 3) begin bad++; $display("FAIL pop_lat: got %0d exp 3", lat); end
        if (bus.pop_data !== 16'h1234) begin bad++; $display("FAIL pop_data: got %h exp 1234", bus.pop_data); end
        if (bus.sp !== 16'hFFFE) begin bad++; $display("FAIL pop_sp: got %h exp fffe", bus.sp); end
        ok = (obs_rd_q.size() == 2) && (obs_rd_q[0] === 16'hFFFC) && (obs_rd_q[1] === 16'hFFFD) && (obs_q.size() == 0);
        if (!ok) begin bad++; $display("FAIL pop_reads: got n=%0d exp rd fffc,fffd", obs_rd_q.size()); end
        @(posedge clk); #1;
        total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b exp 0", bus.done); end
    endtask

    task automatic test_wrap();
        int lat;
        bit ok;
        do_load(16'h0001);
        clear_queues();
        model_push(16'hABCD);
        run_op(STACK_PUSH, 16'hABCD, lat);
        total += 3;
        ok = (obs_q.size() == 2) && (obs_q[0] === 24'h0000AB) && (obs_q[1] === 24'hFFFFCD);
        if (!ok) begin bad++; $display("FAIL wrap_writes: got n=%0d exp 0000<=ab ffff<=cd", obs_q.size()); end
        if (bus.sp !== m_sp) begin bad++; $display("FAIL wrap_sp: got %h exp %h", bus.sp, m_sp); end
        if (bus.sp_wrap_err !== WRAP_EN) begin bad++; $display("FAIL wrap_flag: got %b exp %b", bus.sp_wrap_err, WRAP_EN); end
        do_load(16'hFFFE);
        total++;
        if (bus.sp_wrap_err !== 1'b0) begin bad++; $display("FAIL wrap_clear: got %b exp 0", bus.sp_wrap_err); end
    endtask

    task automatic test_busy_ignore();
        logic [15:0] d;
        bit ok;
        d = 16'($urandom);
        clear_queues();
        model_push(d);
        bus.op = STACK_PUSH; bus.push_data = d; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = STACK_POP; bus.push_data = ~d;
        bus.sp_load = 1'b1; bus.sp_wdata = 16'($urandom);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.sp_load = 1'b0;
        @(posedge clk); #1;
        total += 3;
        if (bus.done !== 1'b1) begin bad++; $display("FAIL busy_done: got %b exp 1", bus.done); end
        if (bus.sp !== m_sp) begin bad++; $display("FAIL busy_sp: got %h exp %h", bus.sp, m_sp); end
        ok = (obs_q.size() == 2) && (obs_q[0] === exp_q[0]) && (obs_q[1] === exp_q[1]);
        if (!ok) begin bad++; $display("FAIL busy_writes: got n=%0d exp %h %h", obs_q.size(), exp_q[0], exp_q[1]); end
        @(posedge clk); #1;
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_requeue: got %b exp 0", bus.busy); end
    endtask

    task automatic test_load_start();
        logic [15:0] v;
        v = 16'($urandom);
        bus.sp_load = 1'b1; bus.start = 1'b1; bus.op = STACK_PUSH; bus.sp_wdata = v;
        @(posedge clk); #1;
        bus.sp_load = 1'b0; bus.start = 1'b0;
        m_sp = v; m_wrap = 1'b0;
        total += 2;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL load_start_busy: got %b exp 0", bus.busy); end
        if (bus.sp !== v) begin bad++; $display("FAIL load_start_sp: got %h exp %h", bus.sp, v); end
        do_load(16'hFFFE);
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [15:0] sp0;
        int lat;
        d = 16'($urandom);
        sp0 = m_sp;
        clear_queues();
        model_push(d);
        model_pop();
        bus.op = STACK_PUSH; bus.push_data = d; bus.start = 1'b1;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!bus.done && lat < 12);
        total++;
        if (lat != 4) begin bad++; $display("FAIL b2b_push_lat: got %0d exp 4", lat); end
        bus.op = STACK_POP;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 12) begin @(posedge clk); #1; lat++; end
        total += 4;
        if (lat != 3) begin bad++; $display("FAIL b2b_pop_lat: got %0d exp 3", lat); end
        if (bus.pop_data !== d) begin bad++; $display("FAIL b2b_pop_data: got %h exp %h", bus.pop_data, d); end
        if (bus.sp !== sp0) begin bad++; $display("FAIL b2b_sp: got %h exp %h", bus.sp, sp0); end
        if (obs_q.size() != 2 || obs_rd_q.size() != 2) begin
            bad++; $display("FAIL b2b_bus: got wr=%0d rd=%0d exp 2 2", obs_q.size(), obs_rd_q.size());
        end
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] d;
        logic [15:0] v;
        stack_op_t o;
        bit ok;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 4))
                    0: v = 16'h0000;
                    1: v = 16'h0001;
                    2: v = 16'hFFFE;
                    3: v = 16'hFFFF;
                    default: v = 16'($urandom);
                endcase
                do_load(v);
            end
            clear_queues();
            d = 16'($urandom);
            o = ($urandom_range(0, 1) == 0) ? STACK_PUSH : STACK_POP;
            if (o == STACK_PUSH) model_push(d);
            else                 model_pop();
            run_op(o, d, lat);
            total += 5;
            if (lat != ((o == STACK_PUSH) ? 4 : 3)) begin bad++; $display("FAIL rnd_lat[%0d]: got %0d op=%0d", n, lat, o); end
            if (bus.sp !== m_sp) begin bad++; $display("FAIL rnd_sp[%0d]: got %h exp %h", n, bus.sp, m_sp); end
            if (bus.pop_data !== m_pop) begin bad++; $display("FAIL rnd_pop[%0d]: got %h exp %h", n, bus.pop_data, m_pop); end
            if (bus.sp_wrap_err !== m_wrap) begin bad++; $display("FAIL rnd_wrap[%0d]: got %b exp %b", n, bus.sp_wrap_err, m_wrap); end
            ok = (obs_q.size() == exp_q.size()) && (obs_rd_q.size() == exp_rd_q.size());
            for (int i = 0; ok && i < exp_q.size(); i++) ok = (obs_q[i] === exp_q[i]);
            for (int i = 0; ok && i < exp_rd_q.size(); i++) ok = (obs_rd_q[i] === exp_rd_q[i]);
            if (!ok) begin
                bad++; $display("FAIL rnd_bus[%0d]: got wr=%0d rd=%0d exp wr=%0d rd=%0d or wrong addr/data",
                                n, obs_q.size(), obs_rd_q.size(), exp_q.size(), exp_rd_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic [15:0] a_hi;
        d = 16'($urandom);
        a_hi = m_sp - 16'd1;
        clear_queues();
        bus.op = STACK_PUSH; bus.push_data = d; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (bus.state !== PUSH_HI) begin bad++; $display("FAIL rstmid_state: got %0d exp PUSH_HI", bus.state); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_mem[a_hi] = d[15:8];
        m_sp = 16'hFFFE; m_pop = 16'h0000; m_wrap = 1'b0;
        total += 4;
        if (bus.state !== IDLE) begin bad++; $display("FAIL rstmid_idle: got %0d exp IDLE", bus.state); end
        if (bus.sp !== 16'hFFFE) begin bad++; $display("FAIL rstmid_sp: got %h exp fffe", bus.sp); end
        if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL rstmid_wr: got %b exp 0", bus.mem_wr); end
        if (bus.pop_data !== 16'h0000) begin bad++; $display("FAIL rstmid_pop: got %h exp 0000", bus.pop_data); end
        repeat (4) @(posedge clk);
        #1;
        total += 2;
        if (obs_q.size() != 1 || obs_q[0] !== {a_hi, d[15:8]}) begin
            bad++; $display("FAIL rstmid_writes: got n=%0d exp one write %h<=%h", obs_q.size(), a_hi, d[15:8]);
        end
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_quiet: got done=%b busy=%b exp 0 0", bus.done, bus.busy);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.op = STACK_PUSH; bus.push_data = 16'h0000;
        bus.sp_load = 1'b0; bus.sp_wdata = 16'h0000;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            m_mem[i] = mem[i];
        end
        test_reset();
        test_push_pop();
        test_wrap();
        test_busy_ignore();
        test_load_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
